// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM encoding,
// clear-sequence length and the index-to-one-hot decode helper.
package reg_write_arbiter_pkg;

   typedef logic [0:0] state_t;

   // INIT holds the bank in clear; RUN arbitrates writes.
   localparam state_t ST_INIT = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

   // Cycles reg_nclr stays low after clr falls, long enough to clear the latches.
   localparam int INIT_CYCLES = 2;

   // Bit 'pos' of the one-hot decode of 'idx'. An index outside the decoded
   // range matches no position, so the decode comes out all-zero.
   function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
      return (idx == pos);
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible requester at or after the
// pointer, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] elig,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   win,
   output logic            valid
);

   // Scan from the farthest candidate back to the pointer so the nearest one wins.
   always_comb begin
      win   = '0;
      valid = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (elig[(int'(ptr) + k) % NREQ]) begin
            win   = PW'((int'(ptr) + k) % NREQ);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one write path into a register bank among
// NREQ requesters; also sequences the bank clear after reset.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NREGS = 8,
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*IDXW-1:0]  req_idx,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       ack,
   output logic [NREGS-1:0]      reg_en,
   output logic [WIDTH-1:0]      wr_data,
   output logic                  reg_nclr,
   output logic                  busy
);

   localparam int PW   = $clog2(NREQ);
   localparam int CNTW = $clog2(INIT_CYCLES + 1);

   state_t            state_reg;
   logic [CNTW-1:0]   cnt_reg;
   logic [PW-1:0]     ptr_reg;
   logic [NREQ-1:0]   ack_reg;
   logic [NREGS-1:0]  reg_en_reg;
   logic [WIDTH-1:0]  wr_data_reg;
   logic              nclr_reg;
   logic              busy_reg;

   logic [IDXW-1:0]   idx_arr  [NREQ];
   logic [WIDTH-1:0]  data_arr [NREQ];

   logic [NREQ-1:0]   elig;
   logic [PW-1:0]     win_idx;
   logic              win_valid;
   logic              grant;
   logic [IDXW-1:0]   sel_idx;
   logic [PW-1:0]     ptr_next;
   logic [NREQ-1:0]   ack_next;
   logic [NREGS-1:0]  reg_en_next;

   // Unpack the per-requester index and data fields.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign idx_arr[gi]  = req_idx[gi*IDXW +: IDXW];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
   end

   // The requester acked this cycle still holds req high, so keep it out of the race.
   assign elig = req & ~ack_reg;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
      .elig  (elig),
      .ptr   (ptr_reg),
      .win   (win_idx),
      .valid (win_valid)
   );

   assign grant    = (state_reg == ST_RUN) && win_valid;
   assign sel_idx  = idx_arr[win_idx];
   assign ptr_next = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
   assign ack_next = grant ? (NREQ'(1) << win_idx) : '0;

   // Out-of-range indices decode to all-zero: the write is acked but dropped.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_decode
      assign reg_en_next[gi] = grant & onehot_bit(32'(sel_idx), gi);
   end

   // Clear sequencing, arbitration state and registered outputs.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg   <= ST_INIT;
         cnt_reg     <= '0;
         ptr_reg     <= '0;
         ack_reg     <= '0;
         reg_en_reg  <= '0;
         wr_data_reg <= '0;
         nclr_reg    <= 1'b0;
         busy_reg    <= 1'b1;
      end else if (state_reg == ST_INIT) begin
         ack_reg    <= '0;
         reg_en_reg <= '0;
         if (cnt_reg == CNTW'(INIT_CYCLES - 1)) begin
            state_reg <= ST_RUN;
            nclr_reg  <= 1'b1;
            busy_reg  <= 1'b0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end else begin
         ack_reg    <= ack_next;
         reg_en_reg <= reg_en_next;
         if (grant) begin
            wr_data_reg <= data_arr[win_idx];
            ptr_reg     <= ptr_next;
         end
      end
   end

   assign ack      = ack_reg;
   assign reg_en   = reg_en_reg;
   assign wr_data  = wr_data_reg;
   assign reg_nclr = nclr_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a
// randomized run against a round-robin reference model.
`timescale 1ns/1ps
module tb_reg_write_arbiter;

   localparam int NREQ   = 4;
   localparam int NREGS  = 8;
   localparam int WIDTH  = 8;
   localparam int IDXW   = 3;
   localparam int NREGS6 = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (NREGS=8)
   logic                  clr;
   logic [NREQ-1:0]       req;
   logic [NREQ*IDXW-1:0]  req_idx;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       ack;
   logic [NREGS-1:0]      reg_en;
   logic [WIDTH-1:0]      wr_data;
   logic                  reg_nclr;
   logic                  busy;

   // Second instance (NREGS=6) for out-of-range indices
   logic                  clr6;
   logic [NREQ-1:0]       req6;
   logic [NREQ*IDXW-1:0]  req_idx6;
   logic [NREQ*WIDTH-1:0] req_data6;
   logic [NREQ-1:0]       ack6;
   logic [NREGS6-1:0]     reg_en6;
   logic [WIDTH-1:0]      wr_data6;
   logic                  reg_nclr6;
   logic                  busy6;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] bank  [NREGS];
   logic [WIDTH-1:0] bank6 [NREGS6];

   reg_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .WIDTH(WIDTH)) dut (
      .clk(clk), .clr(clr), .req(req), .req_idx(req_idx), .req_data(req_data),
      .ack(ack), .reg_en(reg_en), .wr_data(wr_data), .reg_nclr(reg_nclr), .busy(busy)
   );

   reg_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS6), .WIDTH(WIDTH)) dut6 (
      .clk(clk), .clr(clr6), .req(req6), .req_idx(req_idx6), .req_data(req_data6),
      .ack(ack6), .reg_en(reg_en6), .wr_data(wr_data6), .reg_nclr(reg_nclr6), .busy(busy6)
   );

   // Behavioural register banks driven by the arbiter outputs.
   always @(posedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (!reg_nclr) bank[i] <= '0;
         else if (reg_en[i]) bank[i] <= wr_data;
      end
      for (int i = 0; i < NREGS6; i++) begin
         if (!reg_nclr6) bank6[i] <= '0;
         else if (reg_en6[i]) bank6[i] <= wr_data6;
      end
   end

   // Advance one cycle, sample just after the edge, check per-cycle invariants.
   task automatic tick();
      @(posedge clk);
      #1;
      checks++;
      if ($countones(ack) > 1) begin
         failures++;
         $display("FAIL inv_ack_onehot ack=%b required popcount<=1", ack);
      end
      checks++;
      if ($countones(reg_en) > 1) begin
         failures++;
         $display("FAIL inv_en_onehot reg_en=%b required popcount<=1", reg_en);
      end
      checks++;
      if (reg_en != 0 && ack == 0) begin
         failures++;
         $display("FAIL inv_en_implies_ack reg_en=%b ack=%b required ack!=0", reg_en, ack);
      end
      checks++;
      if (!reg_nclr && reg_en != 0) begin
         failures++;
         $display("FAIL inv_clr_no_en reg_nclr=%b reg_en=%b required reg_en=0", reg_nclr, reg_en);
      end
   endtask

   task automatic set_req(input int i, input logic r, input int idx, input int data);
      req[i]                   = r;
      req_idx[i*IDXW +: IDXW]  = IDXW'(idx);
      req_data[i*WIDTH +: WIDTH] = WIDTH'(data);
   endtask

   task automatic set_req6(input int i, input logic r, input int idx, input int data);
      req6[i]                    = r;
      req_idx6[i*IDXW +: IDXW]   = IDXW'(idx);
      req_data6[i*WIDTH +: WIDTH] = WIDTH'(data);
   endtask

   // Reset the main instance and step through INIT; returns at the first RUN cycle.
   task automatic do_reset();
      req = '0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      req = '0;
      clr = 1'b1;
      tick();
      checks++;
      if (reg_nclr !== 1'b0 || busy !== 1'b1 || ack !== '0 || reg_en !== '0 || wr_data !== '0) begin
         failures++;
         $display("FAIL reset_state nclr=%b busy=%b ack=%b en=%b wd=%h required 0 1 0 0 0",
                  reg_nclr, busy, ack, reg_en, wr_data);
      end
      clr = 1'b0;
      tick();
      checks++;
      if (reg_nclr !== 1'b0 || busy !== 1'b1 || ack !== '0 || reg_en !== '0) begin
         failures++;
         $display("FAIL init_cycle2 nclr=%b busy=%b ack=%b en=%b required 0 1 0 0",
                  reg_nclr, busy, ack, reg_en);
      end
      tick();
      checks++;
      if (reg_nclr !== 1'b1 || busy !== 1'b0 || ack !== '0 || reg_en !== '0) begin
         failures++;
         $display("FAIL init_done nclr=%b busy=%b ack=%b en=%b required 1 0 0 0",
                  reg_nclr, busy, ack, reg_en);
      end
      tick();
      checks++;
      if (ack !== '0 || reg_en !== '0) begin
         failures++;
         $display("FAIL idle_run ack=%b en=%b required 0 0", ack, reg_en);
      end
      $display("txn reset done");
   endtask

   task automatic test_single_write();
      do_reset();
      set_req(2, 1'b1, 5, 8'hA5);
      tick();
      checks++;
      if (ack !== 4'b0100 || reg_en !== 8'b0010_0000 || wr_data !== 8'hA5) begin
         failures++;
         $display("FAIL single_write ack=%b en=%b wd=%h required 0100 00100000 a5",
                  ack, reg_en, wr_data);
      end
      req = '0;
      tick();
      checks++;
      if (ack !== '0 || reg_en !== '0 || wr_data !== 8'hA5) begin
         failures++;
         $display("FAIL single_after ack=%b en=%b wd=%h required 0 0 a5", ack, reg_en, wr_data);
      end
      checks++;
      if (bank[5] !== 8'hA5) begin
         failures++;
         $display("FAIL bank_reg5 got=%h required a5", bank[5]);
      end
      $display("txn single write reg5=%h", bank[5]);
   endtask

   task automatic test_fairness();
      logic [NREQ-1:0]  exp_ack;
      logic [NREGS-1:0] exp_en;
      int w;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, 8'h10 + i);
      for (int n = 0; n < 6; n++) begin
         tick();
         w       = n % NREQ;
         exp_ack = NREQ'(1) << w;
         exp_en  = NREGS'(1) << (w + 1);
         checks++;
         if (ack !== exp_ack || reg_en !== exp_en || wr_data !== WIDTH'(8'h10 + w)) begin
            failures++;
            $display("FAIL fairness_%0d ack=%b en=%b wd=%h required %b %b %h",
                     n, ack, reg_en, wr_data, exp_ack, exp_en, WIDTH'(8'h10 + w));
         end
         $display("txn fairness cyc=%0d ack=%b", n, ack);
      end
      req = '0;
      tick();
   endtask

   task automatic test_out_of_range();
      req6 = '0;
      clr6 = 1'b1;
      tick();
      clr6 = 1'b0;
      tick();
      tick();
      set_req6(0, 1'b1, 2, 8'h3C);
      tick();
      checks++;
      if (ack6 !== 4'b0001 || reg_en6 !== 6'b000100) begin
         failures++;
         $display("FAIL oor_prewrite ack=%b en=%b required 0001 000100", ack6, reg_en6);
      end
      req6 = '0;
      tick();
      set_req6(1, 1'b1, 7, 8'hFF);
      tick();
      checks++;
      if (ack6 !== 4'b0010 || reg_en6 !== '0) begin
         failures++;
         $display("FAIL oor_idx7 ack=%b en=%b required 0010 000000", ack6, reg_en6);
      end
      req6 = '0;
      tick();
      set_req6(3, 1'b1, 6, 8'hEE);
      tick();
      checks++;
      if (ack6 !== 4'b1000 || reg_en6 !== '0) begin
         failures++;
         $display("FAIL oor_idx6 ack=%b en=%b required 1000 000000", ack6, reg_en6);
      end
      req6 = '0;
      tick();
      for (int i = 0; i < NREGS6; i++) begin
         checks++;
         if (bank6[i] !== ((i == 2) ? 8'h3C : 8'h00)) begin
            failures++;
            $display("FAIL oor_bank%0d got=%h required %h", i, bank6[i], (i == 2) ? 8'h3C : 8'h00);
         end
      end
      $display("txn out-of-range writes dropped");
   endtask

   task automatic test_mid_reset();
      do_reset();
      set_req(0, 1'b1, 1, 8'h5A);
      clr = 1'b1;
      tick();
      checks++;
      if (ack !== '0 || reg_en !== '0 || reg_nclr !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midrst_abandon ack=%b en=%b nclr=%b busy=%b required 0 0 0 1",
                  ack, reg_en, reg_nclr, busy);
      end
      clr = 1'b0;
      tick();
      checks++;
      if (ack !== '0 || reg_nclr !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midrst_init2 ack=%b nclr=%b busy=%b required 0 0 1", ack, reg_nclr, busy);
      end
      tick();
      checks++;
      if (ack !== '0 || reg_nclr !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_run ack=%b nclr=%b busy=%b required 0 1 0", ack, reg_nclr, busy);
      end
      tick();
      checks++;
      if (ack !== 4'b0001 || reg_en !== 8'b0000_0010 || wr_data !== 8'h5A) begin
         failures++;
         $display("FAIL midrst_ack ack=%b en=%b wd=%h required 0001 00000010 5a",
                  ack, reg_en, wr_data);
      end
      req = '0;
      tick();
      $display("txn mid reset recovered");
   endtask

   task automatic test_req_during_init();
      req = '0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      set_req(3, 1'b1, 0, 8'hC3);
      tick();
      checks++;
      if (ack !== '0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL init_req_c1 ack=%b busy=%b required 0 1", ack, busy);
      end
      tick();
      checks++;
      if (ack !== '0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL init_req_c2 ack=%b busy=%b required 0 0", ack, busy);
      end
      tick();
      checks++;
      if (ack !== 4'b1000 || reg_en !== 8'b0000_0001 || wr_data !== 8'hC3) begin
         failures++;
         $display("FAIL init_req_ack ack=%b en=%b wd=%h required 1000 00000001 c3",
                  ack, reg_en, wr_data);
      end
      req = '0;
      tick();
      $display("txn request during init acked");
   endtask

   task automatic test_random();
      logic             pend  [NREQ];
      int               ridx  [NREQ];
      int               rdata [NREQ];
      int               mptr;
      int               mack;
      int               retire;
      int               win;
      int               j;
      logic [NREQ-1:0]  exp_ack;
      logic [NREGS-1:0] exp_en;
      logic [WIDTH-1:0] exp_wd;
      do_reset();
      mptr   = 0;
      mack   = -1;
      retire = -1;
      exp_wd = '0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i]  = 1'b0;
         ridx[i]  = 0;
         rdata[i] = 0;
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
         // Requesters: the one acked a cycle ago drops or re-requests; idle ones may raise.
         for (int i = 0; i < NREQ; i++) begin
            if (i == retire) begin
               pend[i] = ($urandom_range(0, 1) == 1);
               ridx[i]  = $urandom_range(0, NREGS - 1);
               rdata[i] = $urandom_range(0, 255);
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i]  = 1'b1;
               ridx[i]  = $urandom_range(0, NREGS - 1);
               rdata[i] = $urandom_range(0, 255);
            end
            set_req(i, pend[i], ridx[i], rdata[i]);
         end
         // Reference: first pending requester from the pointer, skipping the one acked now.
         win = -1;
         for (int k = 0; k < NREQ; k++) begin
            j = (mptr + k) % NREQ;
            if (win < 0 && pend[j] && j != mack) win = j;
         end
         tick();
         if (win >= 0) begin
            exp_ack = NREQ'(1) << win;
            exp_en  = NREGS'(1) << ridx[win];
            exp_wd  = WIDTH'(rdata[win]);
            mptr    = (win + 1) % NREQ;
         end else begin
            exp_ack = '0;
            exp_en  = '0;
         end
         checks++;
         if (ack !== exp_ack) begin
            failures++;
            $display("FAIL rand_ack cyc=%0d got=%b required %b", cyc, ack, exp_ack);
         end
         checks++;
         if (reg_en !== exp_en) begin
            failures++;
            $display("FAIL rand_en cyc=%0d got=%b required %b", cyc, reg_en, exp_en);
         end
         checks++;
         if (wr_data !== exp_wd) begin
            failures++;
            $display("FAIL rand_wd cyc=%0d got=%h required %h", cyc, wr_data, exp_wd);
         end
         if (win >= 0)
            $display("txn rand cyc=%0d ack=%b reg_en=%b wr_data=%h", cyc, ack, reg_en, wr_data);
         retire = mack;
         mack   = win;
      end
      req = '0;
      tick();
   endtask

   initial begin
      clr       = 1'b1;
      req       = '0;
      req_idx   = '0;
      req_data  = '0;
      clr6      = 1'b1;
      req6      = '0;
      req_idx6  = '0;
      req_data6 = '0;
      test_reset();
      test_single_write();
      test_fairness();
      test_out_of_range();
      test_mid_reset();
      test_req_during_init();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
